// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : FIFO-draining UART transmitter, LSB-first 8N1.
//            Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int W             = 8,
  parameter int CLKS_PER_BAUD = 868,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_empty,
  output logic         o_rd,
  output logic         o_tx,
  output logic         o_busy
);

  localparam int         c_IDX_W  = (W > 1) ? $clog2(W) : 1;
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_IDX_W-1:0] w_idx_nxt;
  logic [W-1:0]       r_shift;
  logic [W-1:0]       w_shift_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               w_wrap;
  logic               w_last;
  logic               w_pop;

  assign w_wrap = (r_cnt == CNT_W'(CLKS_PER_BAUD - 1));
  assign w_last = (r_idx == c_IDX_W'(W - 1));
  assign w_pop  = (r_state == c_IDLE) && !i_empty && i_rst_n;
  assign o_tx   = r_tx;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      // Counter is parked at zero in IDLE so every bit gets a full period.
      r_cnt   <= (r_state == c_IDLE || w_wrap) ? '0 : r_cnt + CNT_W'(1);
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^i_data;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    case (r_state)
      c_IDLE: begin
        if (w_pop) begin
          w_state_nxt = c_START;
          w_shift_nxt = i_data;
        end
      end
      c_START: begin
        if (w_wrap) begin
          w_state_nxt = c_DATA;
          w_idx_nxt   = '0;
        end
      end
      c_DATA: begin
        if (w_wrap) begin
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = r_idx + c_IDX_W'(1);
          if (w_last) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = c_PARITY;
`else
            w_state_nxt = c_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      c_PARITY: begin
        if (w_wrap) w_state_nxt = c_STOP;
      end
`endif
      c_STOP: begin
        if (w_wrap) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Line level is derived from the upcoming state so o_tx is a clean flop output.
  always_comb begin
    o_rd   = w_pop;
    o_busy = (r_state != c_IDLE);
    case (w_state_nxt)
      c_START:  w_tx_nxt = 1'b0;
      c_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      c_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx: FIFO model, waveform reference
//            model and a mid-bit sampling UART receiver.
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_empty;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_tx;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_tx #(.W(8), .CLKS_PER_BAUD(CPB), .CNT_W(16)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_empty (i_empty),
    .o_rd    (o_rd),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;   // start, 8 data LSB-first, stop (bit 0 = start)
    logic       par;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  logic       exp_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic          s_rd, s_tx, s_busy;
  logic          rx_active = 1'b0;
  logic          rx_prev   = 1'b1;
  int            rx_cnt    = 0;
  int            rx_done   = 0;
  logic [NB-1:0] rx_bits   = '0;
  int            busy_run  = 0;
  int            last_busy_len = 0;
  int            rd_count  = 0;
  int            last_rd_cycle = 0;
  int            rd_gap    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected line waveform: each frame bit held for CPB cycles.
  task automatic push_frame(input logic [7:0] d);
    logic [NB-1:0] f;
    f[0] = 1'b0;
    for (int b = 0; b < 8; b++) f[b+1] = d[b];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NB-1] = 1'b1;
    for (int k = 0; k < NB; k++) repeat (CPB) exp_q.push_back(f[k]);
  endtask

  task automatic rx_step();
    logic [7:0] exp_d;
    if (!i_rst_n) begin
      rx_active = 1'b0;
    end else if (rx_active) begin
      if (rx_cnt % CPB == CPB / 2) begin
        rx_bits[rx_cnt / CPB] = s_tx;
        if (rx_cnt / CPB == NB - 1) begin
          rx_active = 1'b0;
          rx_done++;
          if (sent_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got frame %0h want none (cycle %0d)", rx_bits, cycle);
          end else begin
            exp_d = sent_q.pop_front();
            chk("rx_start", rx_bits[0], 1'b0);
            chk("rx_data", rx_bits[8:1], exp_d);
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", rx_bits[9], ^exp_d);
`endif
            chk("rx_stop", rx_bits[NB-1], 1'b1);
          end
        end
      end
      rx_cnt++;
    end else if (rx_prev && !s_tx) begin
      rx_active = 1'b1;
      rx_cnt    = 1;
    end
    rx_prev = s_tx;
  endtask

  // One clock cycle: present FIFO outputs, sample DUT, check model, clock.
  task automatic cyc();
    logic exp_busy, exp_tx, exp_rd;
    i_empty = (fifo_q.size() == 0);
    if (i_empty) i_data = 8'($urandom);
    else         i_data = fifo_q[0];
    #1;
    s_rd   = o_rd;
    s_tx   = o_tx;
    s_busy = o_busy;
    if (!i_rst_n) begin
      exp_q.delete();
      sent_q.delete();
    end
    exp_busy = (exp_q.size() != 0);
    exp_tx   = exp_busy ? exp_q[0] : 1'b1;
    exp_rd   = i_rst_n && !exp_busy && !i_empty;
    chk("model_tx", s_tx, exp_tx);
    chk("model_busy", s_busy, exp_busy);
    chk("model_rd", s_rd, exp_rd);
    if (exp_busy) void'(exp_q.pop_front());
    if (exp_rd) push_frame(fifo_q[0]);
    rx_step();
    if (s_busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (s_rd) begin
      rd_count++;
      rd_gap = cycle - last_rd_cycle;
      last_rd_cycle = cycle;
    end
    @(posedge clk);
    if (s_rd && fifo_q.size() != 0) sent_q.push_back(fifo_q.pop_front());
    cycle++;
    #1;
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n = 0;
    while (rx_done < target && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_rx", rx_done, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((s_busy || exp_q.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_idle", s_busy, 1'b0);
  endtask

  initial begin
    int n_rd, n_low, n_busy, n;
    i_rst_n = 1'b0;
    i_empty = 1'b1;
    i_data  = '0;
    vecs[0] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[1] = '{8'hA3, 10'b1101000110, 1'b0};
    vecs[2] = '{8'h0F, 10'b1000011110, 1'b0};
    vecs[3] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[4] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[5] = '{8'h80, 10'b1100000000, 1'b1};
    @(posedge clk);
    #1;

    // Reset held with a non-empty FIFO: no pop, line idle.
    fifo_q.push_back(8'h11);
    repeat (5) cyc();
    chk("rst_rd", s_rd, 1'b0);
    chk("rst_tx", s_tx, 1'b1);
    chk("rst_busy", s_busy, 1'b0);
    i_rst_n = 1'b1;
    cyc();
    chk("rd_first_idle", s_rd, 1'b1);
    wait_rx(rx_done + 1, 200);
    wait_idle(200);

    // Directed single-byte frames.
    for (int i = 0; i < 6; i++) begin
      rd_count = 0;
      fifo_q.push_back(vecs[i].data);
      wait_rx(rx_done + 1, 200);
`ifdef UART_TX_PARITY_EN
      chk($sformatf("vec%0d_bits", i), rx_bits[8:0], vecs[i].bits[8:0]);
      chk($sformatf("vec%0d_par", i), rx_bits[9], vecs[i].par);
      chk($sformatf("vec%0d_stop", i), rx_bits[10], 1'b1);
`else
      chk($sformatf("vec%0d_bits", i), rx_bits[9:0], vecs[i].bits);
`endif
      wait_idle(200);
      chk($sformatf("vec%0d_busy_len", i), last_busy_len, FRAME);
      chk($sformatf("vec%0d_rd_pulses", i), rd_count, 1);
    end

    // Back-to-back frames.
    rd_count = 0;
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h0F);
    wait_rx(rx_done + 2, 300);
    chk("b2b_rd_count", rd_count, 2);
    chk("b2b_rd_gap", rd_gap, FRAME + 1);
    wait_idle(200);

    // Empty FIFO.
    n_rd = 0; n_low = 0; n_busy = 0;
    repeat (100) begin
      cyc();
      if (s_rd) n_rd++;
      if (!s_tx) n_low++;
      if (s_busy) n_busy++;
    end
    chk("empty_rd", n_rd, 0);
    chk("empty_tx_low", n_low, 0);
    chk("empty_busy", n_busy, 0);

    // Reset during data bit 3 of 0xFF, next byte waiting.
    fifo_q.push_back(8'hFF);
    n = 0;
    while (!s_rd && n < 50) begin
      cyc();
      n++;
    end
    chk("mid_pop_seen", s_rd, 1'b1);
    fifo_q.push_back(8'h5A);
    repeat (17) cyc();
    chk("mid_busy_before", s_busy, 1'b1);
    i_rst_n = 1'b0;
    cyc();
    chk("mid_rst_tx", s_tx, 1'b1);
    chk("mid_rst_busy", s_busy, 1'b0);
    chk("mid_rst_rd", s_rd, 1'b0);
    repeat (3) cyc();
    i_rst_n = 1'b1;
    wait_rx(rx_done + 1, 200);
    wait_idle(200);

    // Random traffic against the reference model.
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) fifo_q.push_back(8'($urandom));
      cyc();
    end
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || rx_active) && n < 10000) begin
      cyc();
      n++;
    end
    chk("drain_left", fifo_q.size() + exp_q.size(), 0);
    chk("sent_left", sent_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
